// File: rtl/ray_generator.sv
// Raster ray generator: scans H_RES x V_RES pixels row-major and streams float32 ray directions over AXI-Stream.
// Define RAYGEN_CONTINUOUS_EN to keep rescanning frames back to back instead of stopping after one.
module ray_generator #(
  parameter int          H_RES   = 320,
  parameter int          V_RES   = 180,
  parameter logic [31:0] FOCAL_Z = 32'hC3A00000,
  parameter logic [1:0]  SELECT  = 2'b11
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  output logic             busy,
  output logic             frame_done,
  output logic [2:0][31:0] ray_axis_tdata,
  output logic [10:0]      hcount_axis_tdata,
  output logic [9:0]       vcount_axis_tdata,
  output logic [1:0]       select_objs,
  output logic             ray_axis_tvalid,
  input  logic             ray_axis_tready
);

`ifdef RAYGEN_CONTINUOUS_EN
  localparam bit CONTINUOUS = 1'b1;
`else
  localparam bit CONTINUOUS = 1'b0;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [10:0]        next_h;
  logic [9:0]         next_v;
  logic               pending;
  logic               handshake;
  logic               load;
  logic               last_load;
  logic               last_out;
  logic signed [23:0] x_val;
  logic signed [23:0] y_val;

  // Exact conversion for |v| < 2^24: the leading one becomes the hidden bit, no rounding required.
  function automatic logic [31:0] int_to_f32(input logic signed [23:0] v);
    logic [23:0] mag;
    logic [4:0]  msb;
    logic [22:0] mant;
    mag = v[23] ? 24'(-v) : 24'(v);
    msb = '0;
    for (int i = 0; i < 24; i++)
      if (mag[i]) msb = 5'(i);
    mant = 23'(mag << (5'd23 - msb));
    if (mag == '0) return 32'h0000_0000;
    return {v[23], 8'd127 + 8'(msb), mant};
  endfunction

  assign select_objs = SELECT;
  assign x_val       = 24'(next_h) - 24'(H_RES / 2);
  assign y_val       = 24'(V_RES / 2) - 24'(next_v);

  assign handshake = ray_axis_tvalid && ray_axis_tready;
  assign load      = (state == RUN) && pending && (!ray_axis_tvalid || ray_axis_tready);
  assign last_load = (next_h == 11'(H_RES - 1)) && (next_v == 10'(V_RES - 1));
  assign last_out  = handshake && (hcount_axis_tdata == 11'(H_RES - 1))
                               && (vcount_axis_tdata == 10'(V_RES - 1));

  always_ff @(posedge aclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!aresetn) begin
      state             <= IDLE;
      next_h            <= '0;
      next_v            <= '0;
      pending           <= 1'b0;
      busy              <= 1'b0;
      frame_done        <= 1'b0;
      ray_axis_tvalid   <= 1'b0;
      ray_axis_tdata    <= '0;
      hcount_axis_tdata <= '0;
      vcount_axis_tdata <= '0;
    end else begin
      frame_done <= last_out;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            next_h  <= '0;
            next_v  <= '0;
            pending <= 1'b1;
          end
        end
        RUN: begin
          // Output stage refills whenever it is empty or being drained this edge.
          if (load) begin
            ray_axis_tdata    <= {FOCAL_Z, int_to_f32(y_val), int_to_f32(x_val)};
            hcount_axis_tdata <= next_h;
            vcount_axis_tdata <= next_v;
            ray_axis_tvalid   <= 1'b1;
            if (next_h == 11'(H_RES - 1)) begin
              next_h <= '0;
              next_v <= last_load ? 10'd0 : next_v + 10'd1;
            end else begin
              next_h <= next_h + 11'd1;
            end
            if (last_load && !CONTINUOUS) pending <= 1'b0;
          end else if (handshake) begin
            ray_axis_tvalid <= 1'b0;
          end
          if (last_out && !CONTINUOUS) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_generator.sv
// Randomized self-checking bench for ray_generator; expected rays come from real-number float conversion.
module tb_ray_generator;
  localparam int          H    = 320;
  localparam int          V    = 180;
  localparam int          NPIX = H * V;
  localparam logic [31:0] FZ   = 32'hC3A00000;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic             start = 1'b0;
  logic             ray_axis_tready = 1'b0;
  logic             busy;
  logic             frame_done;
  logic [2:0][31:0] ray_axis_tdata;
  logic [10:0]      hcount_axis_tdata;
  logic [9:0]       vcount_axis_tdata;
  logic [1:0]       select_objs;
  logic             ray_axis_tvalid;

  int n_cmp  = 0;
  int n_fail = 0;

  ray_generator dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .start             (start),
    .busy              (busy),
    .frame_done        (frame_done),
    .ray_axis_tdata    (ray_axis_tdata),
    .hcount_axis_tdata (hcount_axis_tdata),
    .vcount_axis_tdata (vcount_axis_tdata),
    .select_objs       (select_objs),
    .ray_axis_tvalid   (ray_axis_tvalid),
    .ray_axis_tready   (ray_axis_tready)
  );

  initial forever #5 aclk = ~aclk;

  // Reference float32 via the simulator's double encoding; integers here are exact in both.
  function automatic logic [31:0] f32(int v);
    real         r;
    logic [63:0] d;
    logic [10:0] e;
    if (v == 0) return 32'h0;
    r = v;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Beat number idx of the scan (wrapping across frames): {z, y, x, hcount, vcount}.
  function automatic logic [116:0] exp_beat(int idx);
    int h;
    int v;
    h = (idx % NPIX) % H;
    v = (idx % NPIX) / H;
    return {FZ, f32(V / 2 - v), f32(h - H / 2), 11'(h), 10'(v)};
  endfunction

  function automatic logic [116:0] beat();
    return {ray_axis_tdata, hcount_axis_tdata, vcount_axis_tdata};
  endfunction

  task automatic apply_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    start = 1'b0;
    ray_axis_tready = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic kick();
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    ray_axis_tready = 1'b0;
    @(negedge aclk);
    n_cmp++;
    if ({ray_axis_tvalid, busy, frame_done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000", {ray_axis_tvalid, busy, frame_done});
    end
    n_cmp++;
    if (beat() !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", beat());
    end
    n_cmp++;
    if (select_objs !== 2'b11) begin
      n_fail++;
      $display("FAIL select_objs: got %b want 11", select_objs);
    end
    aresetn = 1'b1;
  endtask

  task automatic test_first_beat();
    @(negedge aclk);
    ray_axis_tready = 1'b1;
    kick();
    n_cmp++;
    if (ray_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL tvalid_edge_k: got %b want 0", ray_axis_tvalid);
    end
    @(negedge aclk);
    n_cmp++;
    if ({ray_axis_tvalid, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL first_valid_busy: got %b want 11", {ray_axis_tvalid, busy});
    end
    n_cmp++;
    if (beat() !== {32'hC3A00000, 32'h42B40000, 32'hC3200000, 11'd0, 10'd0}) begin
      n_fail++;
      $display("FAIL first_beat: got %h", beat());
    end
    @(negedge aclk);
    n_cmp++;
    if (beat() !== exp_beat(1)) begin
      n_fail++;
      $display("FAIL second_beat: got %h want %h", beat(), exp_beat(1));
    end
  endtask

  task automatic test_reset_abort();
    repeat (50) @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    n_cmp++;
    if ({ray_axis_tvalid, busy, frame_done} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_flags: got %b want 000", {ray_axis_tvalid, busy, frame_done});
    end
    aresetn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge aclk);
      n_cmp++;
      if (frame_done !== 1'b0 || ray_axis_tvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_idle: got fd=%b tvalid=%b want 0 0", frame_done, ray_axis_tvalid);
      end
    end
    kick();
    @(negedge aclk);
    n_cmp++;
    if (ray_axis_tvalid !== 1'b1 || beat() !== exp_beat(0)) begin
      n_fail++;
      $display("FAIL restart_beat: got v=%b %h want %h", ray_axis_tvalid, beat(), exp_beat(0));
    end
  endtask

  task automatic test_stall();
    int idx = 0;
    apply_reset();
    ray_axis_tready = 1'b1;
    kick();
    for (int c = 0; c < 60; c++) begin
      @(negedge aclk);
      if (c >= 21 && c <= 25) begin
        n_cmp++;
        if (ray_axis_tvalid !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_tvalid: cycle %0d got %b want 1", c, ray_axis_tvalid);
        end
      end
      if (ray_axis_tvalid) begin
        n_cmp++;
        if (beat() !== exp_beat(idx)) begin
          n_fail++;
          $display("FAIL stall_beat: idx %0d got %h want %h", idx, beat(), exp_beat(idx));
        end
      end
      ray_axis_tready = !(c >= 20 && c <= 24);
      if (ray_axis_tvalid && ray_axis_tready) idx++;
    end
    n_cmp++;
    if (idx != 55) begin
      n_fail++;
      $display("FAIL stall_count: got %0d handshakes want 55", idx);
    end
  endtask

  task automatic test_random_backpressure();
    int idx = 0;
    bit prev_valid = 1'b0;
    bit prev_hs = 1'b0;
    apply_reset();
    kick();
    for (int c = 0; c < 3000; c++) begin
      @(negedge aclk);
      if (prev_valid && !prev_hs) begin
        n_cmp++;
        if (ray_axis_tvalid !== 1'b1) begin
          n_fail++;
          $display("FAIL tvalid_drop: cycle %0d got 0 want 1", c);
        end
      end
      if (ray_axis_tvalid) begin
        n_cmp++;
        if (beat() !== exp_beat(idx)) begin
          n_fail++;
          $display("FAIL rand_beat: idx %0d got %h want %h", idx, beat(), exp_beat(idx));
        end
      end
      ray_axis_tready = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 31) == 0);
      prev_valid = ray_axis_tvalid;
      prev_hs = ray_axis_tvalid && ray_axis_tready;
      if (prev_hs) idx++;
    end
    start = 1'b0;
    n_cmp++;
    if (idx < 2000) begin
      n_fail++;
      $display("FAIL rand_throughput: got %0d handshakes want >= 2000", idx);
    end
  endtask

  task automatic test_full_frame();
    int hs = 0;
    int fd = 0;
    int gaps = 0;
    int first_c = -1;
    int last_c = -1;
    bit prev_last = 1'b0;
    apply_reset();
    ray_axis_tready = 1'b1;
    kick();
    for (int c = 0; c < NPIX + 10; c++) begin
      @(negedge aclk);
      if (frame_done) begin
        fd++;
        n_cmp++;
        if (!prev_last) begin
          n_fail++;
          $display("FAIL frame_done_timing: pulse at cycle %0d not after last handshake", c);
        end
      end
      if (first_c >= 0 && hs < NPIX && !ray_axis_tvalid) gaps++;
      if (ray_axis_tvalid) begin
        n_cmp++;
        if (beat() !== exp_beat(hs)) begin
          n_fail++;
          $display("FAIL frame_beat: idx %0d got %h want %h", hs, beat(), exp_beat(hs));
        end
        if (hs == 90 * H + 160) begin
          n_cmp++;
          if ({ray_axis_tdata[1], ray_axis_tdata[0], hcount_axis_tdata, vcount_axis_tdata}
              !== {64'h0, 11'd160, 10'd90}) begin
            n_fail++;
            $display("FAIL center_beat: got %h", beat());
          end
        end
        if (hs == NPIX - 1) begin
          n_cmp++;
          if ({ray_axis_tdata[1], ray_axis_tdata[0], hcount_axis_tdata, vcount_axis_tdata}
              !== {32'hC2B20000, 32'h431F0000, 11'd319, 10'd179}) begin
            n_fail++;
            $display("FAIL corner_beat: got %h", beat());
          end
        end
        if (first_c < 0) first_c = c;
        if (hs < NPIX) last_c = c;
      end
      prev_last = ray_axis_tvalid && (hs % NPIX == NPIX - 1);
      if (ray_axis_tvalid) hs++;
    end
    n_cmp++;
    if (gaps != 0 || last_c - first_c != NPIX - 1) begin
      n_fail++;
      $display("FAIL frame_rate: gaps %0d span %0d want 0 %0d", gaps, last_c - first_c, NPIX - 1);
    end
    n_cmp++;
    if (fd != 1) begin
      n_fail++;
      $display("FAIL frame_done_count: got %0d want 1", fd);
    end
`ifdef RAYGEN_CONTINUOUS_EN
    n_cmp++;
    if (hs != NPIX + 10 || {ray_axis_tvalid, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL continuous_end: hs %0d v/b %b want %0d 11", hs, {ray_axis_tvalid, busy}, NPIX + 10);
    end
`else
    n_cmp++;
    if (hs != NPIX || {ray_axis_tvalid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL frame_end: hs %0d v/b %b want %0d 00", hs, {ray_axis_tvalid, busy}, NPIX);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_first_beat();
    test_reset_abort();
    test_stall();
    test_random_backpressure();
    test_full_frame();
    apply_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
